// File: rtl/game_ctl.sv
// ---------------------------------------------------------------------------
// game_ctl - game sequencer for the flappy-style VGA game (40 MHz pixel clock)
//
// Runs the IDLE -> READY -> PLAY -> OVER loop once per frame. It gates bird
// and obstacle motion with a per-frame step pulse, detects bird/obstacle and
// bird/floor collisions, keeps the score, and flags the end of the game for
// the text overlay.
//
// Optional feature macro: GAME_CTL_PAUSE_EN
//   defined   : a right-button rising edge in PLAY toggles the pause flag
//   undefined : paused is held at 0 and the right button has no effect
//
// Ports
//   clk          in   1   pixel clock
//   rst          in   1   synchronous active-high reset
//   frame_start  in   1   1-cycle pulse on the first cycle of vblank
//   left         in   1   left mouse button level (already synchronised)
//   right        in   1   right mouse button level (already synchronised)
//   bird_ypos    in  12   bird top edge, px
//   obst_xpos    in  12   obstacle left edge, px
//   gap_ypos     in  12   top of the obstacle gap, px
//   state        out  2   00 IDLE, 01 READY, 10 PLAY, 11 OVER
//   run          out  1   PLAY and not paused
//   step         out  1   1-cycle motion-advance pulse per frame
//   restart      out  1   1-cycle pulse to reset bird/obstacle positions
//   endgame      out  1   high while in OVER
//   score        out  8   obstacles passed, saturating at 255
//   paused       out  1   pause flag
// ---------------------------------------------------------------------------
module game_ctl #(
    parameter int BIRD_X       = 200,
    parameter int BIRD_W       = 32,
    parameter int BIRD_H       = 32,
    parameter int OBST_W       = 64,
    parameter int GAP_H        = 160,
    parameter int SCREEN_H     = 600,
    parameter int START_FRAMES = 60,
    parameter int OVER_FRAMES  = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        left,
    input  logic        right,
    input  logic [11:0] bird_ypos,
    input  logic [11:0] obst_xpos,
    input  logic [11:0] gap_ypos,
    output logic [1:0]  state,
    output logic        run,
    output logic        step,
    output logic        restart,
    output logic        endgame,
    output logic [7:0]  score,
    output logic        paused
);

`ifdef GAME_CTL_PAUSE_EN
    localparam logic PAUSE_EN = 1'b1;
`else
    localparam logic PAUSE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READY = 2'b01,
        S_PLAY  = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    localparam logic [12:0] C_BIRD_L = 13'(BIRD_X);
    localparam logic [12:0] C_BIRD_R = 13'(BIRD_X + BIRD_W);
    localparam logic [7:0]  C_START  = 8'(START_FRAMES - 1);
    localparam logic [7:0]  C_OVER   = 8'(OVER_FRAMES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_score;
    logic        r_passed;
    logic        r_step;
    logic        r_restart;
    logic        r_run;
    logic        r_endgame;
    logic        r_paused;
    logic        r_left_q;
    logic        r_right_q;

    // All geometry in 13 bits so that 12-bit positions plus sizes never wrap.
    logic [12:0] w_obst_l;
    logic [12:0] w_obst_r;
    logic [12:0] w_bird_t;
    logic [12:0] w_bird_b;
    logic [12:0] w_gap_t;
    logic [12:0] w_gap_b;
    logic        w_hx;
    logic        w_hy;
    logic        w_floor;
    logic        w_hit;
    logic        w_pass;
    logic        w_wrap;
    logic        w_click;
    logic        w_rclick;
    logic        w_eval;

    assign w_obst_l = {1'b0, obst_xpos};
    assign w_obst_r = {1'b0, obst_xpos} + 13'(OBST_W);
    assign w_bird_t = {1'b0, bird_ypos};
    assign w_bird_b = {1'b0, bird_ypos} + 13'(BIRD_H);
    assign w_gap_t  = {1'b0, gap_ypos};
    assign w_gap_b  = {1'b0, gap_ypos} + 13'(GAP_H);

    assign w_hx    = (w_obst_l < C_BIRD_R) && (w_obst_r > C_BIRD_L);
    assign w_hy    = (w_bird_t < w_gap_t) || (w_bird_b > w_gap_b);
    assign w_floor = (w_bird_b >= 13'(SCREEN_H));
    assign w_hit   = (w_hx && w_hy) || w_floor;
    assign w_pass  = (w_obst_r <= C_BIRD_L);
    assign w_wrap  = (w_obst_l > C_BIRD_R);

    // Rising edges against the previous-cycle level: a held button clicks once.
    assign w_click  = left & ~r_left_q;
    assign w_rclick = right & ~r_right_q & PAUSE_EN;

    // Frame evaluation in PLAY is suspended entirely while paused.
    assign w_eval = frame_start & ~r_paused;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_score   <= 8'd0;
            r_passed  <= 1'b0;
            r_step    <= 1'b0;
            r_restart <= 1'b0;
            r_run     <= 1'b0;
            r_endgame <= 1'b0;
            r_paused  <= 1'b0;
            r_left_q  <= 1'b0;
            r_right_q <= 1'b0;
        end else begin
            r_left_q  <= left;
            r_right_q <= right;
            r_step    <= 1'b0;
            r_restart <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_click) begin
                        r_state   <= S_READY;
                        r_restart <= 1'b1;
                        r_score   <= 8'd0;
                        r_passed  <= 1'b0;
                        r_cnt     <= C_START;
                    end
                end
                S_READY: begin
                    // Clicks here belong to the bird controller, not to us.
                    if (frame_start) begin
                        if (r_cnt == 8'd0) begin
                            r_state <= S_PLAY;
                            r_run   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_eval && w_hit) begin
                        r_state   <= S_OVER;
                        r_cnt     <= C_OVER;
                        r_run     <= 1'b0;
                        r_endgame <= 1'b1;
                        r_paused  <= 1'b0;
                    end else begin
                        if (w_eval) begin
                            r_step <= 1'b1;
                            if (w_pass && !r_passed) begin
                                r_passed <= 1'b1;
                                if (r_score != 8'hFF)
                                    r_score <= r_score + 8'd1;
                            end else if (w_wrap) begin
                                r_passed <= 1'b0;
                            end
                        end
                        if (w_rclick) begin
                            r_paused <= ~r_paused;
                            r_run    <= r_paused;
                        end
                    end
                end
                S_OVER: begin
                    if (frame_start && r_cnt != 8'd0)
                        r_cnt <= r_cnt - 8'd1;
                    if (w_click && r_cnt == 8'd0) begin
                        r_state   <= S_IDLE;
                        r_endgame <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign state   = r_state;
    assign run     = r_run;
    assign step    = r_step;
    assign restart = r_restart;
    assign endgame = r_endgame;
    assign score   = r_score;
    assign paused  = r_paused;

endmodule
